// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator car controller.
package elevator_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        DOOR   = 2'd2
    } state_t;

    // Default number of floors served by the car.
    localparam int DEFAULT_BUTTONS_WIDTH = 8;

    // Width of a floor index; a two-floor building still needs one bit.
    function automatic int floor_width(input int floors);
        return (floors <= 2) ? 1 : $clog2(floors);
    endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational request scan: requests at a given floor and whether any
// request exists strictly above or strictly below it.
module elevator_req_scan
    import elevator_pkg::*;
#(
    parameter int BUTTONS_WIDTH = DEFAULT_BUTTONS_WIDTH,
    parameter int FW            = floor_width(BUTTONS_WIDTH)
) (
    input  logic [BUTTONS_WIDTH-1:0] in_levels,
    input  logic [BUTTONS_WIDTH-1:0] up_levels,
    input  logic [BUTTONS_WIDTH-1:0] down_levels,
    input  logic [FW-1:0]            idx,
    output logic                     in_here,
    output logic                     up_here,
    output logic                     down_here,
    output logic                     above,
    output logic                     below
);

    // Walk every floor once, sorting its requests into here/above/below.
    // An index past the top floor simply matches nothing.
    always_comb begin
        in_here   = 1'b0;
        up_here   = 1'b0;
        down_here = 1'b0;
        above     = 1'b0;
        below     = 1'b0;
        for (int i = 0; i < BUTTONS_WIDTH; i++) begin
            if (i == int'(idx)) begin
                in_here   = in_levels[i];
                up_here   = up_levels[i];
                down_here = down_levels[i];
            end else if (i > int'(idx)) begin
                above = above | in_levels[i] | up_levels[i] | down_levels[i];
            end else begin
                below = below | in_levels[i] | up_levels[i] | down_levels[i];
            end
        end
    end

endmodule

// File: rtl/elevator_ctrl.sv
// Collective (SCAN) elevator car controller. Serves latched requests from
// buttons_res, times travel and door dwell with one shared down-counter and
// returns one-cycle clear pulses for every request it serves.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int BUTTONS_WIDTH = DEFAULT_BUTTONS_WIDTH,
    parameter int TRAVEL_CYCLES = 100,
    parameter int DOOR_CYCLES   = 300,
    parameter int FW            = floor_width(BUTTONS_WIDTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
    input  logic [BUTTONS_WIDTH-2:0] active_out_up_levels,
    input  logic [BUTTONS_WIDTH-1:1] active_out_down_levels,
    output logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
    output logic [BUTTONS_WIDTH-2:0] inactivate_out_up_levels,
    output logic [BUTTONS_WIDTH-1:1] inactivate_out_down_levels,
    output logic [FW-1:0]            floor,
    output logic                     dir_up,
    output logic                     moving,
    output logic                     door_open
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);

    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
    localparam logic [FW-1:0] TOP_FLOOR   = FW'(BUTTONS_WIDTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [FW-1:0]     floor_nxt;
    logic              dir_nxt;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_nxt;

    // Which request bits to pulse next cycle, and at which floor.
    logic              clr_in;
    logic              clr_up;
    logic              clr_dn;
    logic [FW-1:0]     clr_floor;

    // Requests with the bits pulsed this cycle masked: buttons_res drops
    // them one cycle after the pulse, so they must not be served twice.
    logic [BUTTONS_WIDTH-1:0] eff_in;
    logic [BUTTONS_WIDTH-1:0] eff_up;
    logic [BUTTONS_WIDTH-1:0] eff_dn;

    logic [FW-1:0]     next_floor;

    logic              c_in, c_up, c_dn, c_above, c_below, c_any;
    logic              n_in, n_up, n_dn, n_above, n_below;
    logic              n_stop, n_ahead;

    logic              want_up;
    logic              hc_up;
    logic              hc_dn;
    logic              hc_dir;

    assign eff_in = active_in_levels & ~inactivate_in_levels;
    assign eff_up = {1'b0, active_out_up_levels & ~inactivate_out_up_levels};
    assign eff_dn = {active_out_down_levels & ~inactivate_out_down_levels, 1'b0};

    // Floor the car reaches at the end of the current travel interval.
    assign next_floor = dir_up ? ((floor == TOP_FLOOR) ? floor : floor + FW'(1))
                               : ((floor == '0)        ? floor : floor - FW'(1));

    elevator_req_scan #(
        .BUTTONS_WIDTH (BUTTONS_WIDTH),
        .FW            (FW)
    ) u_scan_cur (
        .in_levels   (eff_in),
        .up_levels   (eff_up),
        .down_levels (eff_dn),
        .idx         (floor),
        .in_here     (c_in),
        .up_here     (c_up),
        .down_here   (c_dn),
        .above       (c_above),
        .below       (c_below)
    );

    elevator_req_scan #(
        .BUTTONS_WIDTH (BUTTONS_WIDTH),
        .FW            (FW)
    ) u_scan_nxt (
        .in_levels   (eff_in),
        .up_levels   (eff_up),
        .down_levels (eff_dn),
        .idx         (next_floor),
        .in_here     (n_in),
        .up_here     (n_up),
        .down_here   (n_dn),
        .above       (n_above),
        .below       (n_below)
    );

    assign c_any   = c_in | c_up | c_dn;
    assign n_stop  = dir_up ? (n_in | n_up | (n_dn & ~n_above))
                            : (n_in | n_dn | (n_up & ~n_below));
    assign n_ahead = dir_up ? n_above : n_below;

    // Hall bits to clear when the door opens at the current floor: the
    // direction the car will continue in wins; both clear when nothing
    // else is pending anywhere.
    always_comb begin
        hc_up   = 1'b0;
        hc_dn   = 1'b0;
        hc_dir  = dir_up;
        want_up = dir_up ? (c_above | ~c_below) : (c_above & ~c_below);
        if (c_up && c_dn) begin
            if (!c_above && !c_below) begin
                hc_up = 1'b1;
                hc_dn = 1'b1;
            end else if (want_up) begin
                hc_up  = 1'b1;
                hc_dir = 1'b1;
            end else begin
                hc_dn  = 1'b1;
                hc_dir = 1'b0;
            end
        end else if (c_up) begin
            hc_up  = 1'b1;
            hc_dir = 1'b1;
        end else if (c_dn) begin
            hc_dn  = 1'b1;
            hc_dir = 1'b0;
        end
    end

    // Next-state, position, direction, timer and clear-pulse decisions.
    always_comb begin
        state_nxt = state;
        floor_nxt = floor;
        dir_nxt   = dir_up;
        timer_nxt = timer;
        clr_in    = 1'b0;
        clr_up    = 1'b0;
        clr_dn    = 1'b0;
        clr_floor = floor;
        case (state)
            IDLE: begin
                if (c_any) begin
                    state_nxt = DOOR;
                    timer_nxt = DOOR_LOAD;
                    clr_in    = c_in;
                    clr_up    = hc_up;
                    clr_dn    = hc_dn;
                    dir_nxt   = hc_dir;
                end else if (c_above && (dir_up || !c_below)) begin
                    state_nxt = MOVING;
                    timer_nxt = TRAVEL_LOAD;
                    dir_nxt   = 1'b1;
                end else if (c_below) begin
                    state_nxt = MOVING;
                    timer_nxt = TRAVEL_LOAD;
                    dir_nxt   = 1'b0;
                end
            end
            MOVING: begin
                if (timer != '0) begin
                    timer_nxt = timer - TW'(1);
                end else begin
                    floor_nxt = next_floor;
                    clr_floor = next_floor;
                    if (n_stop) begin
                        state_nxt = DOOR;
                        timer_nxt = DOOR_LOAD;
                        clr_in    = n_in;
                        if (dir_up) begin
                            if (n_up) begin
                                clr_up = 1'b1;
                            end else if (n_dn && !n_above) begin
                                clr_dn  = 1'b1;
                                dir_nxt = 1'b0;
                            end
                        end else begin
                            if (n_dn) begin
                                clr_dn = 1'b1;
                            end else if (n_up && !n_below) begin
                                clr_up  = 1'b1;
                                dir_nxt = 1'b1;
                            end
                        end
                    end else if (n_ahead) begin
                        timer_nxt = TRAVEL_LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DOOR: begin
                if (c_any) begin
                    timer_nxt = DOOR_LOAD;
                    clr_in    = c_in;
                    clr_up    = hc_up;
                    clr_dn    = hc_dn;
                    dir_nxt   = hc_dir;
                end else if (timer != '0) begin
                    timer_nxt = timer - TW'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // State register plus registered outputs and one-hot clear pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                      <= IDLE;
            floor                      <= '0;
            dir_up                     <= 1'b1;
            timer                      <= '0;
            moving                     <= 1'b0;
            door_open                  <= 1'b0;
            inactivate_in_levels       <= '0;
            inactivate_out_up_levels   <= '0;
            inactivate_out_down_levels <= '0;
        end else begin
            state     <= state_nxt;
            floor     <= floor_nxt;
            dir_up    <= dir_nxt;
            timer     <= timer_nxt;
            moving    <= (state_nxt == MOVING);
            door_open <= (state_nxt == DOOR);
            for (int i = 0; i < BUTTONS_WIDTH; i++) begin
                inactivate_in_levels[i] <= clr_in && (int'(clr_floor) == i);
            end
            for (int i = 0; i < BUTTONS_WIDTH - 1; i++) begin
                inactivate_out_up_levels[i] <= clr_up && (int'(clr_floor) == i);
            end
            for (int i = 1; i < BUTTONS_WIDTH; i++) begin
                inactivate_out_down_levels[i] <= clr_dn && (int'(clr_floor) == i);
            end
        end
    end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl (8 floors, 4-cycle travel, 3-cycle door).
// The request latches of buttons_res are modelled here: a bit set by the
// stimulus stays up until the cycle after its clear pulse.
module tb_elevator_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] act_in;
    logic [6:0] act_up;
    logic [7:1] act_dn;
    logic [7:0] inact_in;
    logic [6:0] inact_up;
    logic [7:1] inact_dn;
    logic [2:0] floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;

    int n_checks;
    int n_errors;

    elevator_ctrl #(
        .BUTTONS_WIDTH (8),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (3)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .active_in_levels           (act_in),
        .active_out_up_levels       (act_up),
        .active_out_down_levels     (act_dn),
        .inactivate_in_levels       (inact_in),
        .inactivate_out_up_levels   (inact_up),
        .inactivate_out_down_levels (inact_dn),
        .floor                      (floor),
        .dir_up                     (dir_up),
        .moving                     (moving),
        .door_open                  (door_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance k clock cycles, sampling 1 time unit after each edge; the
    // request latch drops a bit one cycle after its clear pulse.
    task automatic go(input int k);
        logic [7:0] pi;
        logic [6:0] pu;
        logic [7:1] pd;
        for (int j = 0; j < k; j++) begin
            pi = inact_in;
            pu = inact_up;
            pd = inact_dn;
            @(posedge clk);
            #1;
            act_in = act_in & ~pi;
            act_up = act_up & ~pu;
            act_dn = act_dn & ~pd;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_floor"}, 32'(floor), 32'd0);
        check({tag, "_dir"}, 32'(dir_up), 32'd1);
        check({tag, "_moving"}, 32'(moving), 32'd0);
        check({tag, "_door"}, 32'(door_open), 32'd0);
        check({tag, "_pulses"}, {10'd0, inact_in, inact_up, inact_dn}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        act_in   = '0;
        act_up   = '0;
        act_dn   = '0;

        // Reset held with a request pending.
        #2;
        act_in = 8'h08;
        go(3);
        check_reset_state("rst");

        // Floor 0 -> 3 for in[3].
        reset = 1'b0;
        go(1);
        check("mv_start", 32'(moving), 32'd1);
        check("mv_fl0", 32'(floor), 32'd0);
        go(3);
        check("mv_c4_fl", 32'(floor), 32'd0);
        go(1);
        check("mv_c5_fl", 32'(floor), 32'd1);
        go(4);
        check("mv_c9_fl", 32'(floor), 32'd2);
        go(3);
        check("mv_c12_door", 32'(door_open), 32'd0);
        go(1);
        check("c13_fl", 32'(floor), 32'd3);
        check("c13_door", 32'(door_open), 32'd1);
        check("c13_moving", 32'(moving), 32'd0);
        check("c13_pin", 32'(inact_in), 32'h08);
        go(1);
        check("c14_pin", 32'(inact_in), 32'h00);
        go(1);
        check("c15_door", 32'(door_open), 32'd1);
        go(1);
        check("c16_door", 32'(door_open), 32'd0);
        check("c16_moving", 32'(moving), 32'd0);

        // Move to 4, then up[4] at the car's floor.
        act_in = 8'h10;
        go(5);
        check("f4_arrive", 32'(floor), 32'd4);
        check("f4_pin", 32'(inact_in), 32'h10);
        go(3);
        check("f4_idle", 32'(door_open), 32'd0);
        act_up = 7'h10;
        go(1);
        check("up4_door", 32'(door_open), 32'd1);
        check("up4_pup", 32'(inact_up), 32'h10);
        check("up4_moving", 32'(moving), 32'd0);
        go(1);
        check("up4_stale", 32'(inact_up), 32'h00);
        go(1);
        check("up4_open3", 32'(door_open), 32'd1);
        go(1);
        check("up4_closed", 32'(door_open), 32'd0);
        check("up4_floor", 32'(floor), 32'd4);

        // Down to 2, then in[2] re-pressed while the door is open.
        act_in = 8'h04;
        go(1);
        check("dn2_dir", 32'(dir_up), 32'd0);
        check("dn2_moving", 32'(moving), 32'd1);
        go(8);
        check("dn2_floor", 32'(floor), 32'd2);
        check("dn2_pin", 32'(inact_in), 32'h04);
        go(1);
        act_in = 8'h04;
        go(1);
        check("reopen_pin", 32'(inact_in), 32'h04);
        check("reopen_door", 32'(door_open), 32'd1);
        go(1);
        check("reopen_once", 32'(inact_in), 32'h00);
        go(1);
        check("reopen_open3", 32'(door_open), 32'd1);
        go(1);
        check("reopen_closed", 32'(door_open), 32'd0);

        // From 0: up[2], down[5], in[6].
        reset = 1'b1;
        #1;
        check_reset_state("rst2");
        go(1);
        reset  = 1'b0;
        act_up = 7'h04;
        act_dn = 7'h10;
        act_in = 8'h40;
        go(9);
        check("sc_f2", 32'(floor), 32'd2);
        check("sc_f2_pup", 32'(inact_up), 32'h04);
        go(16);
        check("sc_f5_pass", 32'(floor), 32'd5);
        check("sc_f5_moving", 32'(moving), 32'd1);
        go(4);
        check("sc_f6", 32'(floor), 32'd6);
        check("sc_f6_pin", 32'(inact_in), 32'h40);
        check("sc_f6_dir", 32'(dir_up), 32'd1);
        go(4);
        check("sc_rev_dir", 32'(dir_up), 32'd0);
        go(4);
        check("sc_f5", 32'(floor), 32'd5);
        check("sc_f5_pdn", 32'(inact_dn), 32'h10);
        check("sc_f5_door", 32'(door_open), 32'd1);

        // Only down[7] from floor 0.
        reset = 1'b1;
        go(1);
        reset  = 1'b0;
        act_dn = 7'h40;
        go(29);
        check("d7_floor", 32'(floor), 32'd7);
        check("d7_pdn", 32'(inact_dn), 32'h40);
        check("d7_dir", 32'(dir_up), 32'd0);

        // Same trip, reset asserted at floor 4.
        reset = 1'b1;
        go(1);
        reset  = 1'b0;
        act_dn = 7'h40;
        go(17);
        check("mid_floor4", 32'(floor), 32'd4);
        reset = 1'b1;
        #1;
        check_reset_state("mid_rst");
        go(2);
        check_reset_state("mid_hold");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
